resync3: RTL and testbench

Three-stage clock-domain resynchroniser for single-bit or narrow asynchronous inputs. It samples an input that may change at any time relative to `i_clk` through a chain of flip-flops and presents a metastability-hardened copy on `o_q`. Edge-detect pulses are derived from the settled output. It sits at every asynchronous boundary: pins, foreign-clock strobes, and resets fed into logic.

---
 rtl/resync3_if.sv | 22 ++
 rtl/resync3.sv | 47 ++++
 tb/tb_resync3.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/resync3_if.sv
// Signal bundle for the resync3 synchroniser: async data in, reset load value,
// synchronised level and edge pulses out.
`timescale 1ns/100ps
interface resync3_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i_rst_d;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;

  modport master (
    output i_rst_d, i_d,
    input  o_q, o_rise, o_fall
  );

  modport slave (
    input  i_rst_d, i_d,
    output o_q, o_rise, o_fall
  );
endinterface

// File: rtl/resync3.sv
// Multi-stage flip-flop resynchroniser with per-bit registered rise/fall pulses.
// Each bit is an independent chain; every output comes straight from a flop.
`timescale 1ns/100ps
module resync3 #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 3   // legal range 2..8
) (
  input  logic       i_clk,
  input  logic       i_nrst,  // synchronous, active-high despite the name
  resync3_if.slave   bus
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Pulses are computed one edge early from the last two stages, so they are
  // registered yet still coincide with the o_q transition.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one
    // unassigned and no latch can be inferred.
    for (int k = 0; k < STAGES; k++) sync_d[k] = bus.i_rst_d;
    rise_d = '0;
    fall_d = '0;
    if (!i_nrst) begin
      sync_d[0] = bus.i_d;
      for (int k = 1; k < STAGES; k++) sync_d[k] = sync_q[k-1];
      rise_d =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall_d = ~sync_q[STAGES-2] &  sync_q[STAGES-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // assignments above belong to combinational next-state logic.
  always_ff @(posedge i_clk) begin
    sync_q <= sync_d;
    rise_q <= rise_d;
    fall_q <= fall_d;
  end

  assign bus.o_q    = sync_q[STAGES-1];
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;

endmodule

// File: tb/tb_resync3.sv
// Directed bench for resync3: per-edge vector table on the default instance,
// plus glitch, async-random and WIDTH=4/STAGES=2 sequences.
`timescale 1ns/100ps
module tb_resync3;

  typedef struct {
    logic rst;
    logic rst_d;
    logic d;
    logic q;
    logic rise;
    logic fall;
  } vec_t;

  logic clk = 1'b0;
  logic nrst;
  int   n_vec = 0;
  int   n_err = 0;

  resync3_if #(.WIDTH(1)) ifc ();
  resync3_if #(.WIDTH(4)) ifc2 ();

  resync3 #(.WIDTH(1), .STAGES(3)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (ifc)
  );

  resync3 #(.WIDTH(4), .STAGES(2)) dut2 (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (ifc2)
  );

  always #41.5 clk = ~clk;  // 83 ns period

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs half a cycle before the edge, look at outputs 1 ns after it.
  task automatic apply(input logic rst, input logic rst_d, input logic d);
    @(negedge clk);
    nrst        = rst;
    ifc.i_rst_d = rst_d;
    ifc.i_d     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic h [4];

    nrst         = 1'b1;
    ifc.i_rst_d  = 1'b1;
    ifc.i_d      = 1'b0;
    ifc2.i_rst_d = 4'h0;
    ifc2.i_d     = 4'h0;

    //                rst rst_d d  q  rise fall
    // reset load with rst_d=1, then release: q holds 2 edges, then falls
    vecs.push_back('{1, 1, 0, 1, 0, 0});
    vecs.push_back('{1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 0});
    // latency: d rises before edge N, q rises after edge N+2
    vecs.push_back('{1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 0, 0});
    // d low again, then a 2-cycle high pulse
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0});
    // mid-stream reset with rst_d=0 while q=1: q drops, no fall pulse
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0});
    // mid-stream reset with rst_d=1 while q=0: q jumps, no rise pulse
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].rst_d, vecs[i].d);
      check($sformatf("v%0d q", i),    {7'd0, ifc.o_q},    {7'd0, vecs[i].q});
      check($sformatf("v%0d rise", i), {7'd0, ifc.o_rise}, {7'd0, vecs[i].rise});
      check($sformatf("v%0d fall", i), {7'd0, ifc.o_fall}, {7'd0, vecs[i].fall});
    end

    // Sub-cycle glitch between edges is never sampled
    @(negedge clk);
    #10 ifc.i_d = 1'b1;
    #10 ifc.i_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_sample();
      check($sformatf("glitch%0d q", i),    {7'd0, ifc.o_q},    8'h00);
      check($sformatf("glitch%0d rise", i), {7'd0, ifc.o_rise}, 8'h00);
      check($sformatf("glitch%0d fall", i), {7'd0, ifc.o_fall}, 8'h00);
    end

    // Async random input: chain and sample history are all zero here
    for (int i = 0; i < 4; i++) h[i] = 1'b0;
    @(negedge clk);
    fork
      begin
        #0.3;
        for (int i = 0; i < 1000; i++) begin
          ifc.i_d = 1'($urandom);
          #1;
        end
      end
      begin
        for (int c = 0; c < 11; c++) begin
          @(posedge clk);
          h[3] = h[2];
          h[2] = h[1];
          h[1] = h[0];
          h[0] = ifc.i_d;
          #1;
          check($sformatf("rnd%0d q", c),    {7'd0, ifc.o_q},    {7'd0, h[2]});
          check($sformatf("rnd%0d rise", c), {7'd0, ifc.o_rise}, {7'd0, h[2] & ~h[3]});
          check($sformatf("rnd%0d fall", c), {7'd0, ifc.o_fall}, {7'd0, ~h[2] & h[3]});
        end
      end
    join
    ifc.i_d = 1'b0;

    // WIDTH=4, STAGES=2 instance: two-edge latency, per-bit pulses
    @(negedge clk);
    ifc2.i_d = 4'hA;
    edge_sample();
    check("w4 e1 q",    {4'd0, ifc2.o_q},    8'h00);
    check("w4 e1 rise", {4'd0, ifc2.o_rise}, 8'h00);
    edge_sample();
    check("w4 e2 q",    {4'd0, ifc2.o_q},    8'h0A);
    check("w4 e2 rise", {4'd0, ifc2.o_rise}, 8'h0A);
    check("w4 e2 fall", {4'd0, ifc2.o_fall}, 8'h00);
    @(negedge clk);
    ifc2.i_d = 4'h5;
    edge_sample();
    check("w4 e3 q",    {4'd0, ifc2.o_q},    8'h0A);
    check("w4 e3 rise", {4'd0, ifc2.o_rise}, 8'h00);
    edge_sample();
    check("w4 e4 q",    {4'd0, ifc2.o_q},    8'h05);
    check("w4 e4 rise", {4'd0, ifc2.o_rise}, 8'h05);
    check("w4 e4 fall", {4'd0, ifc2.o_fall}, 8'h0A);
    // reset load of all ones, then release with d=5 held
    @(negedge clk);
    nrst         = 1'b1;
    ifc2.i_rst_d = 4'hF;
    edge_sample();
    check("w4 rst q",    {4'd0, ifc2.o_q},    8'h0F);
    check("w4 rst rise", {4'd0, ifc2.o_rise}, 8'h00);
    check("w4 rst fall", {4'd0, ifc2.o_fall}, 8'h00);
    @(negedge clk);
    nrst = 1'b0;
    edge_sample();
    check("w4 rel1 q",    {4'd0, ifc2.o_q},    8'h0F);
    check("w4 rel1 fall", {4'd0, ifc2.o_fall}, 8'h00);
    edge_sample();
    check("w4 rel2 q",    {4'd0, ifc2.o_q},    8'h05);
    check("w4 rel2 rise", {4'd0, ifc2.o_rise}, 8'h00);
    check("w4 rel2 fall", {4'd0, ifc2.o_fall}, 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
